// File: rtl/count_capture16.sv
// -----------------------------------------------------------------------------
// count_capture16
//   Captures the value of a free-running 16-bit counter on every rising edge of
//   a trigger level and queues the captures in a small show-ahead FIFO for a
//   valid/ready consumer. Triggers that arrive while the FIFO is full (and not
//   being popped in the same cycle) are dropped and flagged.
//
// Parameters
//   DEPTH      FIFO entries; power of two, 2..16.
//
// Ports
//   clock0     in   single clock, rising edge
//   reset      in   synchronous, active-high
//   count      in   16  upstream counter value
//   trig       in   capture trigger level
//   cap_valid  out  head entry available
//   cap_ready  in   consumer accepts head when cap_valid & cap_ready
//   cap_data   out  16  head entry, zero while cap_valid is low
//   level      out  $clog2(DEPTH)+1  stored entries, 0..DEPTH
//   overflow   out  sticky: a trigger has been dropped since reset
//   ovf_cnt    out  8   saturating dropped-trigger count
//                       (present only when CAPTURE_OVF_CNT_EN is defined)
//
// Optional feature macro: CAPTURE_OVF_CNT_EN
// -----------------------------------------------------------------------------
module count_capture16 #(
  parameter int DEPTH = 4
) (
  input  logic                   clock0,
  input  logic                   reset,
  input  logic [15:0]            count,
  input  logic                   trig,
  output logic                   cap_valid,
  input  logic                   cap_ready,
  output logic [15:0]            cap_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef CAPTURE_OVF_CNT_EN
  ,
  output logic [7:0]             ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic            trig_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     mem_q [DEPTH];

  logic capture, pop, full, push, drop;

  // ---------------------------------------------------------------------------
  // Control: edge detect, push/pop/drop decisions, next state
  // ---------------------------------------------------------------------------
  always_comb begin
    capture    = trig & ~trig_q;
    pop        = cap_valid & cap_ready;
    full       = (level_q == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = capture & (~full | pop);
    drop       = capture & full & ~pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;

    // Pointers are AW bits wide and DEPTH is 2**AW, so they wrap for free.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock0) begin
    if (reset) begin
      // trig_q resets high so a trigger already asserted out of reset is not
      // mistaken for a fresh rising edge.
      trig_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      trig_q     <= trig;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; cap_data is masked while the FIFO is empty. When
  // full with a simultaneous pop, wr_ptr == rd_ptr and the head slot is
  // recycled as the new tail, which is exactly FIFO order.
  always_ff @(posedge clock0) begin
    if (push && !reset) mem_q[wr_ptr_q] <= count;
  end

`ifdef CAPTURE_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clock0) begin
    if (reset) ovf_cnt_q <= 8'h00;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cap_valid = (level_q != '0);
  assign cap_data  = cap_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_capture16.sv
// Directed bench for count_capture16 with a queue scoreboard: every accepted
// capture is pushed when the trigger edge is driven and retired when the
// consumer pops. All outputs are compared one time unit after every edge.
module tb_count_capture16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock0 = 1'b0;
  logic          reset  = 1'b1;
  logic [15:0]   count  = 16'h0000;
  logic          trig   = 1'b0;
  logic          cap_ready = 1'b0;
  logic          cap_valid;
  logic [15:0]   cap_data;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef CAPTURE_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  count_capture16 #(.DEPTH(DEPTH)) dut (
    .clock0    (clock0),
    .reset     (reset),
    .count     (count),
    .trig      (trig),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cap_data  (cap_data),
    .level     (level),
    .overflow  (overflow)
`ifdef CAPTURE_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clock0 = ~clock0;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard / reference state
  logic [15:0] exp_q[$];
  logic        m_trig_q = 1'b1;
  logic        m_ovf    = 1'b0;
  int          m_ovfcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict from pre-edge inputs, advance the model at the edge,
  // then compare every output and step the free-running count.
  task automatic tick();
    logic        cap, pop, full;
    logic [15:0] cnt;
    cap  = trig && !m_trig_q;
    pop  = (exp_q.size() != 0) && cap_ready;
    full = (exp_q.size() == DEPTH);
    cnt  = count;
    @(posedge clock0);
    if (reset) begin
      exp_q.delete();
      m_ovf    = 1'b0;
      m_ovfcnt = 0;
      m_trig_q = 1'b1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (cap) begin
        if (!full || pop) exp_q.push_back(cnt);
        else begin
          m_ovf = 1'b1;
          if (m_ovfcnt != 255) m_ovfcnt++;
        end
      end
      m_trig_q = trig;
    end
    #1;
    chk("sb_level", 32'(level), 32'(exp_q.size()));
    chk("sb_valid", 32'(cap_valid), 32'(exp_q.size() != 0));
    chk("sb_data", 32'(cap_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    chk("sb_overflow", 32'(overflow), 32'(m_ovf));
`ifdef CAPTURE_OVF_CNT_EN
    chk("sb_ovf_cnt", 32'(ovf_cnt), 32'(m_ovfcnt));
`endif
    count = count + 16'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Two cycles high, two low: consecutive captures are four counts apart.
  task automatic trig_pulse();
    trig = 1'b1; ticks(2);
    trig = 1'b0; ticks(2);
  endtask

  initial begin
    logic [15:0] ord [4];
    ord[0] = 16'h0005; ord[1] = 16'h0009; ord[2] = 16'h000D; ord[3] = 16'h0011;

    // Reset state
    reset = 1'b1; ticks(2);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(cap_valid), 32'd0);
    chk("rst_data", 32'(cap_data), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0; ticks(2);

    // Single capture at 0x0010
    count = 16'h0010; trig = 1'b1; tick();
    chk("single_valid", 32'(cap_valid), 32'd1);
    chk("single_data", 32'(cap_data), 32'h0010);
    chk("single_level", 32'(level), 32'd1);
    trig = 1'b0; tick();
    chk("single_hold", 32'(cap_data), 32'h0010);
    cap_ready = 1'b1; tick();
    chk("single_pop_valid", 32'(cap_valid), 32'd0);
    chk("single_pop_data", 32'(cap_data), 32'h0);
    ticks(2);                      // ready while empty: no effect
    chk("empty_ready_level", 32'(level), 32'd0);
    cap_ready = 1'b0;

    // Order and drain
    count = 16'h0005;
    for (int i = 0; i < 4; i++) trig_pulse();
    chk("order_level", 32'(level), 32'd4);
    cap_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order_pop%0d", i), 32'(cap_data), 32'(ord[i]));
      tick();
    end
    chk("drain_valid", 32'(cap_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    cap_ready = 1'b0;

    // Push+pop at full
    count = 16'h0020;
    for (int i = 0; i < 4; i++) trig_pulse();
    chk("pp_full_level", 32'(level), 32'd4);
    count = 16'h0100; trig = 1'b1; cap_ready = 1'b1; tick();
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_overflow", 32'(overflow), 32'd0);
    chk("pp_head", 32'(cap_data), 32'h0024);
    trig = 1'b0; cap_ready = 1'b0; tick();
    cap_ready = 1'b1; ticks(3);
    chk("pp_last", 32'(cap_data), 32'h0100);
    tick();
    chk("pp_empty", 32'(cap_valid), 32'd0);
    cap_ready = 1'b0;

    // Overflow: five triggers, no pops
    count = 16'h0200;
    for (int i = 0; i < 5; i++) trig_pulse();
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(cap_data), 32'h0200);
`ifdef CAPTURE_OVF_CNT_EN
    chk("ovf_cnt1", 32'(ovf_cnt), 32'd1);
`endif
    cap_ready = 1'b1; ticks(5);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    cap_ready = 1'b0;

    // Reset with trig held high, level 3 at assertion
    reset = 1'b1; ticks(1); reset = 1'b0; ticks(1);
    count = 16'h0300;
    trig_pulse(); trig_pulse();
    trig = 1'b1; tick();
    chk("rst3_level", 32'(level), 32'd3);
    reset = 1'b1; ticks(2);
    reset = 1'b0; ticks(3);
    chk("rst3_after_level", 32'(level), 32'd0);
    chk("rst3_after_valid", 32'(cap_valid), 32'd0);
    chk("rst3_after_ovf", 32'(overflow), 32'd0);
    trig = 1'b0; tick();
    trig = 1'b1; tick();
    chk("rst3_recapture", 32'(level), 32'd1);
    trig = 1'b0; cap_ready = 1'b1; ticks(2); cap_ready = 1'b0;

    // Reset wins over a simultaneous capture
    trig = 1'b1; reset = 1'b1; tick();
    chk("rst_prio_level", 32'(level), 32'd0);
    reset = 1'b0; trig = 1'b0; ticks(2);

    // Counter wrap captured verbatim
    count = 16'hFFFF; trig = 1'b1; tick();
    trig = 1'b0; tick();
    count = 16'h0000; trig = 1'b1; tick();
    trig = 1'b0;
    chk("wrap_level", 32'(level), 32'd2);
    chk("wrap_first", 32'(cap_data), 32'hFFFF);
    cap_ready = 1'b1; tick();
    chk("wrap_second", 32'(cap_data), 32'h0000);
    chk("wrap_second_valid", 32'(cap_valid), 32'd1);
    tick(); cap_ready = 1'b0;

`ifdef CAPTURE_OVF_CNT_EN
    // Saturation: fill, then 300 drops
    for (int i = 0; i < 4; i++) trig_pulse();
    for (int i = 0; i < 300; i++) begin
      trig = 1'b1; tick(); trig = 1'b0; tick();
    end
    chk("ovf_cnt_sat", 32'(ovf_cnt), 32'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
